// File: rtl/raybox_pkg.sv
// Shared constants and types for the raybox pixel path: frame geometry,
// pixel classes and the packed column entry kept by the trace buffer.
package raybox_pkg;

  localparam int H_RES      = 640;
  localparam int V_RES      = 480;
  localparam int V_MID      = 240;
  localparam int MAX_HEIGHT = 240;

  localparam int COL_W   = 10;
  localparam int HEIGHT_W = 8;
  localparam int ENTRY_W = HEIGHT_W + 1;

  localparam logic [1:0] PC_CEIL   = 2'd0;
  localparam logic [1:0] PC_FLOOR  = 2'd1;
  localparam logic [1:0] PC_WALL_L = 2'd2;
  localparam logic [1:0] PC_WALL_D = 2'd3;

  typedef struct packed {
    logic                side;
    logic [HEIGHT_W-1:0] height;
  } col_entry_t;

  function automatic logic [HEIGHT_W-1:0] clamp_height(
    input logic [HEIGHT_W-1:0] h,
    input logic [HEIGHT_W-1:0] limit
  );
    logic [HEIGHT_W-1:0] r;
    if (h > limit) begin
      r = limit;
    end else begin
      r = h;
    end
    return r;
  endfunction

endpackage

// File: rtl/trace_buffer_if.sv
// Tracer write port and scan/pixel signals of the trace buffer, bundled with
// master (tracer + timing generator side) and slave (buffer side) views.
interface trace_buffer_if;
  logic       store;
  logic [9:0] column;
  logic       side;
  logic [7:0] height;
  logic       tracer_enable;
  logic       frame_start;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       visible;
  logic       pix_blank;
  logic [1:0] pix_class;

  modport master (
    output store, column, side, height, frame_start, hpos, vpos, visible,
    input  tracer_enable, pix_blank, pix_class
  );

  modport slave (
    input  store, column, side, height, frame_start, hpos, vpos, visible,
    output tracer_enable, pix_blank, pix_class
  );
endinterface

// File: rtl/column_ram.sv
// Simple dual-port column store: one write port, one registered read port.
// Contents are never reset; the owner masks stale data.
module column_ram #(
  parameter int DEPTH = 1280,
  parameter int WIDTH = 9,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Write port and registered read port share the clock
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/trace_buffer.sv
// Double-buffered column store between tracer and pixel pipeline; the banks
// swap only at frame start once the back bank holds a complete frame.
module trace_buffer #(
  parameter int H_RES      = raybox_pkg::H_RES,
  parameter int V_MID      = raybox_pkg::V_MID,
  parameter int MAX_HEIGHT = raybox_pkg::MAX_HEIGHT
) (
  input  logic          clk,
  input  logic          reset,
  trace_buffer_if.slave bus
);
  import raybox_pkg::*;

  localparam int         DEPTH      = 2 * H_RES;
  localparam int         AW         = $clog2(DEPTH);
  localparam logic [9:0] H_RES_C    = 10'(H_RES);
  localparam logic [9:0] H_LAST_C   = 10'(H_RES - 1);
  localparam logic [9:0] V_MID_C    = 10'(V_MID);
  localparam logic [7:0] MAX_H_C    = 8'(MAX_HEIGHT);
  localparam logic [AW-1:0] BANK1_BASE = AW'(H_RES);

  logic front_sel_q, front_sel_d;
  logic front_valid_q, front_valid_d;
  logic back_done_q, back_done_d;
  logic tracer_enable_q, tracer_enable_d;

  logic [9:0] vpos_s1_q, vpos_s1_d;
  logic       visible_s1_q, visible_s1_d;
  logic       hpos_ok_s1_q, hpos_ok_s1_d;
  logic       front_valid_s1_q, front_valid_s1_d;

  logic [1:0] pix_class_q, pix_class_d;
  logic       pix_blank_q, pix_blank_d;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  col_entry_t       wr_entry;
  logic [AW-1:0]    rd_addr;
  logic [ENTRY_W-1:0] rd_data;
  col_entry_t       rd_entry;
  logic             hpos_ok;

  logic [10:0] vpos_ext;
  logic [10:0] h_ext;
  logic [10:0] mid_ext;
  logic        wall;

  // Bank layout is bank-major: bank 0 at 0..H_RES-1, bank 1 at H_RES..2*H_RES-1
  always_comb begin
    wr_en          = bus.store && tracer_enable_q && (bus.column < H_RES_C);
    wr_entry.side  = bus.side;
    wr_entry.height = clamp_height(bus.height, MAX_H_C);
    if (front_sel_q) begin
      wr_addr = AW'(bus.column);
    end else begin
      wr_addr = BANK1_BASE + AW'(bus.column);
    end
    hpos_ok = (bus.hpos < H_RES_C);
    if (!hpos_ok) begin
      rd_addr = '0;
    end else if (front_sel_q) begin
      rd_addr = BANK1_BASE + AW'(bus.hpos);
    end else begin
      rd_addr = AW'(bus.hpos);
    end
  end

  column_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_entry),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign rd_entry = rd_data;

  // Swap only on frame start with a completed back bank (registered flag)
  always_comb begin
    front_sel_d   = front_sel_q;
    front_valid_d = front_valid_q;
    back_done_d   = back_done_q;
    if (bus.frame_start && back_done_q) begin
      front_sel_d   = !front_sel_q;
      front_valid_d = 1'b1;
      back_done_d   = 1'b0;
    end else if (wr_en && (bus.column == H_LAST_C)) begin
      back_done_d = 1'b1;
    end else begin
      back_done_d = back_done_q;
    end
    tracer_enable_d = !back_done_d;
  end

  // Stage 1 side-band: scan position travels alongside the RAM read
  always_comb begin
    vpos_s1_d        = bus.vpos;
    visible_s1_d     = bus.visible;
    hpos_ok_s1_d     = hpos_ok;
    front_valid_s1_d = front_valid_q;
  end

  assign vpos_ext = {1'b0, vpos_s1_q};
  assign h_ext    = {3'b000, rd_entry.height};
  assign mid_ext  = 11'(V_MID);

  // Stage 2: V_MID - h <= vpos < V_MID + h, rearranged so nothing goes negative
  always_comb begin
    pix_class_d = PC_CEIL;
    pix_blank_d = 1'b1;
    wall        = 1'b0;
    if (visible_s1_q) begin
      pix_blank_d = 1'b0;
      wall = front_valid_s1_q && hpos_ok_s1_q && (rd_entry.height != 8'd0) &&
             (vpos_ext + h_ext >= mid_ext) && (vpos_ext < mid_ext + h_ext);
      if (wall) begin
        pix_class_d = rd_entry.side ? PC_WALL_D : PC_WALL_L;
      end else if (vpos_s1_q < V_MID_C) begin
        pix_class_d = PC_CEIL;
      end else begin
        pix_class_d = PC_FLOOR;
      end
    end else begin
      pix_class_d = PC_CEIL;
      pix_blank_d = 1'b1;
    end
  end

  // State, pipeline and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      front_sel_q      <= 1'b0;
      front_valid_q    <= 1'b0;
      back_done_q      <= 1'b0;
      tracer_enable_q  <= 1'b0;
      vpos_s1_q        <= 10'd0;
      visible_s1_q     <= 1'b0;
      hpos_ok_s1_q     <= 1'b0;
      front_valid_s1_q <= 1'b0;
      pix_class_q      <= PC_CEIL;
      pix_blank_q      <= 1'b1;
    end else begin
      front_sel_q      <= front_sel_d;
      front_valid_q    <= front_valid_d;
      back_done_q      <= back_done_d;
      tracer_enable_q  <= tracer_enable_d;
      vpos_s1_q        <= vpos_s1_d;
      visible_s1_q     <= visible_s1_d;
      hpos_ok_s1_q     <= hpos_ok_s1_d;
      front_valid_s1_q <= front_valid_s1_d;
      pix_class_q      <= pix_class_d;
      pix_blank_q      <= pix_blank_d;
    end
  end

  assign bus.tracer_enable = tracer_enable_q;
  assign bus.pix_class     = pix_class_q;
  assign bus.pix_blank     = pix_blank_q;

endmodule
